cpu_fetch: RTL and testbench

Instruction fetch stage for the CHIP-8 core. It sits between program memory and the decode/execute stage, and it owns program-counter writes into the CPU register file. The PC write goes in through pc_en/pc_wr, and the current PC comes back on pc_rd. Each instruction is two byte reads from byte-wide synchronous memory; the bytes are assembled into a 16-bit big-endian opcode and presented downstream with a valid/ready handshake. A redirect input from execute (jumps, calls, returns, skips) reloads the PC and discards any fetch in flight.

---
 rtl/chip8_pkg.sv | 17 +
 rtl/cpu_fetch_if.sv | 32 +++
 rtl/cpu_fetch.sv | 168 ++++++++++++++++
 tb/tb_cpu_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 core definitions: fetch defaults, instruction size and the
// fetch FSM state encoding.
package chip8_pkg;

  localparam logic [15:0] PC_RESET_DEFAULT = 16'h0200;
  localparam int          MEM_AW_DEFAULT   = 12;
  localparam int          INSTR_BYTES      = 2;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_CAP  = 3'd3,
    S_OUT  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/cpu_fetch_if.sv
// Fetch-stage bus: program memory port, regfile PC port, execute redirect
// and the opcode valid/ready channel to decode.
interface cpu_fetch_if
  import chip8_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEFAULT
) ();

  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic [15:0]       pc_rd;
  logic              pc_en;
  logic [15:0]       pc_wr;
  logic              redirect;
  logic [15:0]       redirect_pc;
  logic [15:0]       opcode;
  logic [15:0]       opcode_pc;
  logic              opcode_valid;
  logic              opcode_ready;

  modport master (
    output mem_rd_en, mem_addr, pc_en, pc_wr, opcode, opcode_pc, opcode_valid,
    input  mem_rd_data, pc_rd, redirect, redirect_pc, opcode_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, pc_en, pc_wr, opcode, opcode_pc, opcode_valid,
    output mem_rd_data, pc_rd, redirect, redirect_pc, opcode_ready
  );

endinterface

// File: rtl/cpu_fetch.sv
// CHIP-8 instruction fetch: two byte reads per opcode, big-endian assembly,
// PC ownership through the regfile write port, and redirect handling.
module cpu_fetch
  import chip8_pkg::*;
#(
  parameter logic [15:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          MEM_AW   = MEM_AW_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  cpu_fetch_if.master bus
);

  localparam logic [MEM_AW-1:0] ADDR_ONE  = MEM_AW'(1);
  localparam logic [MEM_AW-1:0] ADDR_STEP = MEM_AW'(INSTR_BYTES);

  function automatic logic [15:0] zext_addr(input logic [MEM_AW-1:0] a);
    logic [15:0] r;
    r = 16'h0000;
    r[MEM_AW-1:0] = a;
    return r;
  endfunction

  fetch_state_t      state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       opcode_q, opcode_d;
  logic [15:0]       opcode_pc_q, opcode_pc_d;
  logic              valid_q, valid_d;

  logic              redir_s;
  logic              fire_s;
  logic [MEM_AW-1:0] pc_addr_s;
  logic              mem_rd_en_s;
  logic [MEM_AW-1:0] mem_addr_s;
  logic              pc_en_s;
  logic [15:0]       pc_wr_s;
  logic              unused_s;

  assign pc_addr_s = bus.pc_rd[MEM_AW-1:0];
  assign redir_s   = bus.redirect && (state_q != S_INIT);
  assign fire_s    = valid_q && bus.opcode_ready;
  // Upper address bits are architecturally ignored.
  assign unused_s  = ^{bus.pc_rd[15:MEM_AW], bus.redirect_pc[15:MEM_AW]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect always restarts at S_HI.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: state_d = S_HI;
      S_HI:   state_d = redir_s ? S_HI : S_LO;
      S_LO:   state_d = redir_s ? S_HI : S_CAP;
      S_CAP:  state_d = redir_s ? S_HI : S_OUT;
      S_OUT: begin
        if (redir_s || fire_s) begin
          state_d = S_HI;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Memory strobe and regfile PC write; redirect owns the single PC write slot.
  always_comb begin
    mem_rd_en_s = 1'b0;
    mem_addr_s  = pc_addr_s;
    pc_en_s     = 1'b0;
    pc_wr_s     = 16'h0000;
    if (rst) begin
      mem_rd_en_s = 1'b0;
    end else if (redir_s) begin
      pc_en_s = 1'b1;
      pc_wr_s = zext_addr(bus.redirect_pc[MEM_AW-1:0]);
    end else begin
      case (state_q)
        S_INIT: begin
          pc_en_s = 1'b1;
          pc_wr_s = PC_RESET;
        end
        S_HI: begin
          mem_rd_en_s = 1'b1;
        end
        S_LO: begin
          mem_rd_en_s = 1'b1;
          mem_addr_s  = pc_addr_s + ADDR_ONE;
        end
        S_CAP: begin
          pc_en_s = 1'b1;
          pc_wr_s = zext_addr(pc_addr_s + ADDR_STEP);
        end
        S_OUT: begin
          mem_rd_en_s = 1'b0;
        end
        default: begin
          mem_rd_en_s = 1'b0;
        end
      endcase
    end
  end

  // Opcode assembly and presentation registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q        <= 8'h00;
      opcode_q    <= 16'h0000;
      opcode_pc_q <= 16'h0000;
      valid_q     <= 1'b0;
    end else begin
      hi_q        <= hi_d;
      opcode_q    <= opcode_d;
      opcode_pc_q <= opcode_pc_d;
      valid_q     <= valid_d;
    end
  end

  // Datapath next-state; a redirect drops any partial or presented opcode.
  always_comb begin
    hi_d        = hi_q;
    opcode_d    = opcode_q;
    opcode_pc_d = opcode_pc_q;
    valid_d     = valid_q;
    if (redir_s) begin
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_HI: begin
          opcode_pc_d = zext_addr(pc_addr_s);
        end
        S_LO: begin
          hi_d = bus.mem_rd_data;
        end
        S_CAP: begin
          opcode_d = {hi_q, bus.mem_rd_data};
          valid_d  = 1'b1;
        end
        S_OUT: begin
          if (fire_s) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
        default: begin
          valid_d = valid_q;
        end
      endcase
    end
  end

  assign bus.mem_rd_en    = mem_rd_en_s;
  assign bus.mem_addr     = mem_addr_s;
  assign bus.pc_en        = pc_en_s;
  assign bus.pc_wr        = pc_wr_s;
  assign bus.opcode       = opcode_q;
  assign bus.opcode_pc    = opcode_pc_q;
  assign bus.opcode_valid = valid_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch with a byte memory and regfile PC model, a handshake
// scoreboard, and a table of redirect targets.
module tb_cpu_fetch;
  import chip8_pkg::*;

  typedef struct {
    logic [15:0] target;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp_wr;
    logic [11:0] rd_hi;
    logic [11:0] rd_lo;
    logic [15:0] exp_op;
    logic [15:0] exp_next;
  } vec_t;

  typedef struct packed {
    logic [15:0] op;
    logic [15:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_fetch_if #(.MEM_AW(12)) bus ();

  cpu_fetch #(.PC_RESET(16'h0200), .MEM_AW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  mem [0:4095];
  logic [7:0]  rd_q = 8'h00;
  logic [15:0] pc_q = 16'h0000;

  always @(posedge clk) begin
    if (bus.mem_rd_en) rd_q <= mem[bus.mem_addr];
    if (bus.pc_en) pc_q <= bus.pc_wr;
  end
  assign bus.mem_rd_data = rd_q;
  assign bus.pc_rd       = pc_q;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  logic [11:0] rd_log[$];
  logic        rst_prev = 1'b0;
  vec_t        vecs[4];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    smp();
    while (!bus.opcode_valid && n < budget) begin
      tick();
      smp();
      n++;
    end
    check16("wait_valid", 16'(bus.opcode_valid), 16'h1);
  endtask

  task automatic check_reads(input string name, input logic [11:0] a0, input logic [11:0] a1);
    check16({name, "_rd_count"}, 16'(rd_log.size()), 16'd2);
    check16({name, "_rd_hi"}, 16'(rd_log[0]), 16'(a0));
    check16({name, "_rd_lo"}, 16'(rd_log[1]), 16'(a1));
  endtask

  initial begin
    int   n;
    exp_t e;
    vec_t v;

    rst              = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 16'h0000;
    bus.opcode_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'h60; mem[12'h201] = 8'h2A;
    mem[12'h202] = 8'h11; mem[12'h203] = 8'h22;
    mem[12'h300] = 8'h12; mem[12'h301] = 8'h34;

    vecs[0] = '{16'h0400, 8'hA2, 8'hF0, 16'h0400, 12'h400, 12'h401, 16'hA2F0, 16'h0402};
    vecs[1] = '{16'h0FFF, 8'hAB, 8'hCD, 16'h0FFF, 12'hFFF, 12'h000, 16'hABCD, 16'h0001};
    vecs[2] = '{16'h0123, 8'h3C, 8'h45, 16'h0123, 12'h123, 12'h124, 16'h3C45, 16'h0125};
    vecs[3] = '{16'hF456, 8'h8A, 8'hB4, 16'h0456, 12'h456, 12'h457, 16'h8AB4, 16'h0458};

    // Monitor: protocol rules, reset values and scoreboard on each handshake.
    fork
      forever begin
        @(negedge clk);
        if (bus.mem_rd_en) rd_log.push_back(bus.mem_addr);
        if (rst_prev) begin
          check16("rst_opcode", bus.opcode, 16'h0000);
          check16("rst_opcode_pc", bus.opcode_pc, 16'h0000);
          check16("rst_valid", 16'(bus.opcode_valid), 16'h0);
        end
        if (rst) begin
          check16("rst_mem_rd_en", 16'(bus.mem_rd_en), 16'h0);
          check16("rst_pc_en", 16'(bus.pc_en), 16'h0);
        end else begin
          check16("rd_exclusive", 16'(bus.mem_rd_en & (bus.pc_en | bus.opcode_valid)), 16'h0);
          if (bus.opcode_valid && bus.opcode_ready) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_handshake: got opcode %h expected none", bus.opcode);
            end else begin
              e = sb.pop_front();
              check16("sb_opcode", bus.opcode, e.op);
              check16("sb_opcode_pc", bus.opcode_pc, e.pc);
            end
          end
        end
        rst_prev = rst;
      end
    join_none

    // Reset release and first fetch.
    repeat (3) tick();
    sb.push_back('{16'h602A, 16'h0200});
    rd_log.delete();
    rst = 1'b0;
    smp();
    check16("init_pc_en", 16'(bus.pc_en), 16'h1);
    check16("init_pc_wr", bus.pc_wr, 16'h0200);
    tick();
    wait_valid(8, n);
    check16("first_latency", 16'(n + 1), 16'd4);
    check16("first_opcode", bus.opcode, 16'h602A);
    check16("first_opcode_pc", bus.opcode_pc, 16'h0200);
    check16("first_pc", bus.pc_rd, 16'h0202);
    check_reads("first", 12'h200, 12'h201);

    // Stall with ready low, then handshake.
    for (int k = 0; k < 5; k++) begin
      tick();
      smp();
      check16("stall_valid", 16'(bus.opcode_valid), 16'h1);
      check16("stall_opcode", bus.opcode, 16'h602A);
      check16("stall_mem_rd_en", 16'(bus.mem_rd_en), 16'h0);
      check16("stall_pc", bus.pc_rd, 16'h0202);
    end
    tick();
    bus.opcode_ready = 1'b1;
    smp();
    tick();
    bus.opcode_ready = 1'b0;
    rd_log.delete();
    smp();
    check16("after_hs_rd_en", 16'(bus.mem_rd_en), 16'h1);
    check16("after_hs_addr", 16'(bus.mem_addr), 16'h0202);
    check16("after_hs_valid", 16'(bus.opcode_valid), 16'h0);

    // Redirect while in S_LO drops the half-fetched opcode.
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0300;
    smp();
    check16("redir_lo_pc_en", 16'(bus.pc_en), 16'h1);
    check16("redir_lo_pc_wr", bus.pc_wr, 16'h0300);
    check16("redir_lo_rd_en", 16'(bus.mem_rd_en), 16'h0);
    tick();
    bus.redirect = 1'b0;
    sb.push_back('{16'h1234, 16'h0300});
    rd_log.delete();
    wait_valid(8, n);
    check16("redir_lo_latency", 16'(n), 16'd3);
    check16("redir_lo_opcode", bus.opcode, 16'h1234);
    check16("redir_lo_pc", bus.pc_rd, 16'h0302);
    check_reads("redir_lo", 12'h300, 12'h301);

    // Table: redirect coincident with a handshake in S_OUT.
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      tick();
      mem[v.rd_hi]     = v.hi;
      mem[v.rd_lo]     = v.lo;
      bus.redirect     = 1'b1;
      bus.redirect_pc  = v.target;
      bus.opcode_ready = 1'b1;
      smp();
      check16("vec_pc_en", 16'(bus.pc_en), 16'h1);
      check16("vec_pc_wr", bus.pc_wr, v.exp_wr);
      check16("vec_rd_en", 16'(bus.mem_rd_en), 16'h0);
      tick();
      bus.redirect     = 1'b0;
      bus.opcode_ready = 1'b0;
      sb.push_back('{v.exp_op, v.exp_wr});
      rd_log.delete();
      smp();
      check16("vec_valid_clear", 16'(bus.opcode_valid), 16'h0);
      check16("vec_hi_addr", 16'(bus.mem_addr), 16'(v.rd_hi));
      tick();
      wait_valid(8, n);
      check16("vec_opcode", bus.opcode, v.exp_op);
      check16("vec_next_pc", bus.pc_rd, v.exp_next);
      check_reads("vec", v.rd_hi, v.rd_lo);
    end
    tick();
    bus.opcode_ready = 1'b1;
    smp();
    tick();
    bus.opcode_ready = 1'b0;
    smp();
    check16("sb_drained", 16'(sb.size()), 16'h0);

    // Reset during S_LO, then during a presented opcode.
    tick();
    rst = 1'b1;
    smp();
    tick();
    rst = 1'b0;
    smp();
    check16("rst_lo_pc", bus.pc_rd, 16'h0458);
    check16("rst_lo_restart_wr", bus.pc_wr, 16'h0200);
    sb.push_back('{16'h602A, 16'h0200});
    tick();
    wait_valid(8, n);
    check16("rst_lo_latency", 16'(n + 1), 16'd4);
    tick();
    rst = 1'b1;
    e = sb.pop_back();
    smp();
    tick();
    rst = 1'b0;
    smp();
    check16("rst_out_restart_en", 16'(bus.pc_en), 16'h1);
    check16("rst_out_restart_wr", bus.pc_wr, 16'h0200);
    sb.push_back(e);
    tick();
    wait_valid(8, n);
    tick();
    bus.opcode_ready = 1'b1;
    smp();
    tick();
    bus.opcode_ready = 1'b0;
    smp();
    check16("final_drained", 16'(sb.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
